if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV64I pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit word and its PC into the IF/ID pipeline register for decode.
- Handles hazard-unit stalls, EX-stage branch redirects/flushes and end-of-program halt, and flags misaligned redirect targets.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- MEM_BYTES, 96, instruction memory size in bytes; last legal fetch address is MEM_BYTES-4.
- NOP_INST, 32'h00000013, addi x0,x0,0; inserted into IF/ID on reset and squash.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- redirect  in  1  EX stage: branch/jump taken, flush fetched instruction
- redirect_pc  in  64  target of taken branch
- imem_addr  out  64  byte address to instruction memory (= pc, combinational)
- imem_inst  in  32  instruction word returned for imem_addr (same cycle)
- ifid_pc  out  64  PC of instruction held in IF/ID
- ifid_inst  out  32  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  state == HALT
- fault  out  1  state == FAULT (sticky)

Behaviour:
- State machine: RUN, HALT, FAULT. Reset -> RUN.
- Reset (async, reset_n=0), all values hold while asserted:
  - pc=RESET_PC; ifid_pc=0; ifid_inst=NOP_INST; ifid_valid=0; halted=0; fault=0.
- imem_addr = pc at all times, including in HALT and FAULT.
- Priority per rising edge: reset > FAULT > redirect > stall > normal fetch.
- RUN, redirect=1:
  - If redirect_pc[1:0]!=0: FAULT; pc holds; IF/ID squashed (ifid_inst=NOP_INST, ifid_valid=0).
  - Else: pc<=redirect_pc; IF/ID squashed. This is a 1-cycle bubble. Redirect wins over a simultaneous stall.
- RUN, stall=1, redirect=0: pc, ifid_pc, ifid_inst and ifid_valid all hold.
- RUN, normal fetch, pc <= MEM_BYTES-4: ifid_pc<=pc; ifid_inst<=imem_inst; ifid_valid<=1; pc<=pc+4 (64-bit wrap, no carry-out).
- RUN, normal fetch, pc > MEM_BYTES-4: HALT; pc holds; ifid_inst<=NOP_INST; ifid_valid<=0. No out-of-range word is ever marked valid.
- HALT:
  - IF/ID holds NOP with valid=0; stall ignored.
  - redirect with an aligned target: pc<=redirect_pc, back to RUN. This lets a trailing backward branch still in the pipeline resume the loop.
  - redirect with a misaligned target: FAULT.
- FAULT: terminal until reset. pc frozen; ifid_valid=0; all inputs ignored.
- Latency: an instruction at address A appears on ifid_* one edge after pc==A with stall=0 and redirect=0.
- Steady-state throughput: one instruction per cycle.
- Redirect target A is fetched on the edge after the redirect edge, so it appears on ifid_* two edges after redirect.

Decomposition:
- Shared pipeline package holds:
  - XLEN=64, INST_W=32, NOP_INST constant;
  - fetch state enum {RUN, HALT, FAULT};
  - an if_id_t struct {pc, inst, valid}, reused by the ID stage.
- One natural sub-module: if_id_reg. It is the IF/ID register with hold (stall) and squash (load NOP, valid=0) controls, reset_n async.
- The PC/FSM logic stays in if_stage.

Test Plan:
- Reset then free-run, memory holding the team program: ifid_pc sequence 0,4,8,...; at 0 ifid_inst=32'h00000B13, at 16 ifid_inst=32'h01600BB3; ifid_valid=1 from the first edge after reset release.
- Stall held 3 cycles with pc=20: pc stays 20; ifid_pc=16 and ifid_inst=32'h01600BB3 unchanged for 3 cycles; fetch of 20 resumes on the edge after stall drops.
- Redirect to 64'h48 while pc=36, stall=1 on the same edge: the next edge gives ifid_valid=0 and ifid_inst=NOP_INST; the following edge gives ifid_pc=64'h48, ifid_inst=32'h001B8B93.
- Free-run to end: after ifid_pc=92 the next edge sets halted=1 and ifid_valid=0, with pc held at 96; a later redirect to 64'h10 clears halted and fetches 16.
- Redirect to 64'h22: fault=1 and pc holds. A subsequent aligned redirect and stall toggling leave fault=1, pc and ifid_valid=0 unchanged. reset_n pulse low mid-cycle immediately clears pc to 0 and fault to 0.
- Asynchronous reset asserted between edges during normal fetch: outputs take their reset values without waiting for clk, then resume cleanly from pc=0 after release.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its consumers.
// Holds widths, the NOP encoding, fetch FSM states and the IF/ID bundle.
package if_stage_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t RUN   = 2'd0;
    localparam fetch_state_t HALT  = 2'd1;
    localparam fetch_state_t FAULT = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
// The slave side is the fetch stage; the master side is its environment.
interface if_stage_if;
    import if_stage_pkg::*;

    logic              stall;
    logic              redirect;
    logic [XLEN-1:0]   redirect_pc;
    logic [XLEN-1:0]   imem_addr;
    logic [INST_W-1:0] imem_inst;
    logic [XLEN-1:0]   ifid_pc;
    logic [INST_W-1:0] ifid_inst;
    logic              ifid_valid;
    logic              halted;
    logic              fault;

    modport slave (
        input  stall,
        input  redirect,
        input  redirect_pc,
        input  imem_inst,
        output imem_addr,
        output ifid_pc,
        output ifid_inst,
        output ifid_valid,
        output halted,
        output fault
    );

    modport master (
        output stall,
        output redirect,
        output redirect_pc,
        output imem_inst,
        input  imem_addr,
        input  ifid_pc,
        input  ifid_inst,
        input  ifid_valid,
        input  halted,
        input  fault
    );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with hold and squash controls.
// Squash wins over hold; a squash keeps the stale pc but drops the word.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP = NOP_INST
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   hold,
    input  logic   squash,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.pc    <= '0;
            q.inst  <= NOP;
            q.valid <= 1'b0;
        end else if (squash) begin
            q.inst  <= NOP;
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetch FSM and the IF/ID register.
// Redirects beat stalls; fetching past the last word halts until redirected.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0]   RESET_PC  = 64'h0,
    parameter int                MEM_BYTES = 96,
    parameter logic [INST_W-1:0] NOP       = NOP_INST
) (
    input  logic     clk,
    input  logic     reset_n,
    if_stage_if.slave bus
);

    localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            hold;
    logic            squash;
    if_id_t          fetch_d;
    if_id_t          ifid_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold          = 1'b0;
        squash        = 1'b0;
        fetch_d.pc    = pc_q;
        fetch_d.inst  = bus.imem_inst;
        fetch_d.valid = 1'b1;
        unique case (1'b1)
            (state_q == FAULT): begin
                squash = 1'b1;
            end
            (state_q == HALT): begin
                squash = 1'b1;
                if (bus.redirect) begin
                    if (misaligned(bus.redirect_pc)) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = bus.redirect_pc;
                        state_d = RUN;
                    end
                end
            end
            (state_q == RUN): begin
                if (bus.redirect) begin
                    squash = 1'b1;
                    if (misaligned(bus.redirect_pc)) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = bus.redirect_pc;
                    end
                end else if (bus.stall) begin
                    hold = 1'b1;
                end else if (pc_q <= LAST_PC) begin
                    pc_d = pc_q + 64'd4;
                end else begin
                    // Never let an out-of-range word reach decode
                    state_d = HALT;
                    squash  = 1'b1;
                end
            end
            default: begin
                state_d = FAULT;
                squash  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    if_stage_if_id_reg #(
        .NOP(NOP)
    ) u_if_id_reg (
        .clk    (clk),
        .reset_n(reset_n),
        .hold   (hold),
        .squash (squash),
        .d      (fetch_d),
        .q      (ifid_q)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.ifid_pc    = ifid_q.pc;
    assign bus.ifid_inst  = ifid_q.inst;
    assign bus.ifid_valid = ifid_q.valid;
    assign bus.halted     = (state_q == HALT);
    assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_if_stage.sv
// Directed and random stimulus for if_stage against a behavioural model.
// The model tracks pc, IF/ID contents and halt/fault flags directly.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam int MEM_BYTES = 96;
    localparam logic [31:0] OOR_WORD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    if_stage_if bus ();

    logic [31:0] mem [32];

    int n_assert = 0;
    int n_fail = 0;

    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_inst;
    logic        m_valid;
    logic        m_halt;
    logic        m_fault;

    if_stage #(
        .RESET_PC (64'h0),
        .MEM_BYTES(MEM_BYTES),
        .NOP      (NOP_INST)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_inst = (bus.imem_addr < 64'(MEM_BYTES))
                         ? mem[bus.imem_addr[6:2]] : OOR_WORD;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 64'h0;
        m_ifid_pc = 64'h0;
        m_inst    = NOP_INST;
        m_valid   = 1'b0;
        m_halt    = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_edge(input logic s, input logic r,
                              input logic [63:0] rpc);
        if (m_fault) begin
            m_inst  = NOP_INST;
            m_valid = 1'b0;
        end else if (r) begin
            m_inst  = NOP_INST;
            m_valid = 1'b0;
            if (rpc % 4 != 0) begin
                m_fault = 1'b1;
                m_halt  = 1'b0;
            end else begin
                m_pc   = rpc;
                m_halt = 1'b0;
            end
        end else if (m_halt) begin
            m_inst  = NOP_INST;
            m_valid = 1'b0;
        end else if (s) begin
            m_valid = m_valid;
        end else if (m_pc + 4 <= MEM_BYTES) begin
            m_ifid_pc = m_pc;
            m_inst    = mem[m_pc[6:2]];
            m_valid   = 1'b1;
            m_pc      = m_pc + 4;
        end else begin
            m_halt  = 1'b1;
            m_inst  = NOP_INST;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
        chk({tag, ".valid"}, 64'(bus.ifid_valid), 64'(m_valid));
        chk({tag, ".inst"}, 64'(bus.ifid_inst), 64'(m_inst));
        if (m_valid)
            chk({tag, ".ifid_pc"}, bus.ifid_pc, m_ifid_pc);
        chk({tag, ".halted"}, 64'(bus.halted), 64'(m_halt));
        chk({tag, ".fault"}, 64'(bus.fault), 64'(m_fault));
    endtask

    task automatic step(input string tag, input logic s, input logic r,
                        input logic [63:0] rpc);
        bus.stall       = s;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        @(posedge clk);
        model_edge(s, r, rpc);
        #1;
        check_all(tag);
    endtask

    task automatic rand_phase(input int n);
        logic s;
        logic r;
        logic [63:0] rpc;
        for (int i = 0; i < n; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 9) == 0);
            rpc = 64'($urandom_range(0, 27)) << 2;
            step("rand", s, r, rpc);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0B13;
        mem[4]  = 32'h0160_0BB3;
        mem[18] = 32'h001B_8B93;

        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 64'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.ifid_pc", bus.ifid_pc, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        step("run0", 0, 0, 0);
        chk("run0.word", 64'(bus.ifid_inst), 64'h0000_0B13);
        repeat (4) step("run", 0, 0, 0);
        chk("run16.word", 64'(bus.ifid_inst), 64'h0160_0BB3);
        chk("run16.pc", bus.imem_addr, 64'd20);

        repeat (3) step("stall", 1, 0, 0);
        chk("stall.ifid_pc", bus.ifid_pc, 64'd16);
        repeat (4) step("resume", 0, 0, 0);
        chk("resume.pc", bus.imem_addr, 64'd36);

        step("redir_stall", 1, 1, 64'h48);
        step("redir_tgt", 0, 0, 0);
        chk("redir_tgt.pc", bus.ifid_pc, 64'h48);
        chk("redir_tgt.word", 64'(bus.ifid_inst), 64'h001B_8B93);

        for (int i = 0; i < 8 && !m_halt; i++) step("tail", 0, 0, 0);
        chk("tail.halted", 64'(bus.halted), 64'd1);
        chk("tail.pc", bus.imem_addr, 64'd96);
        step("halt_stall", 1, 0, 0);
        step("halt_idle", 0, 0, 0);
        step("halt_redir", 0, 1, 64'h10);
        step("halt_resume", 0, 0, 0);
        chk("halt_resume.pc", bus.ifid_pc, 64'h10);

        rand_phase(80);

        step("mis", 0, 1, 64'h22);
        chk("mis.fault", 64'(bus.fault), 64'd1);
        step("flt_redir", 1, 1, 64'h10);
        step("flt_redir2", 0, 1, 64'h8);
        step("flt_stall", 1, 0, 0);
        step("flt_idle", 0, 0, 0);

        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        @(negedge clk);
        reset_n = 1'b1;

        repeat (6) step("post", 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("asyncrst");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) step("again", 0, 0, 0);

        rand_phase(60);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
